// File: rtl/uart_avalon_bridge_if.sv
// uart_avalon_bridge_if: UART framer rx/tx handshake plus Avalon-MM master bus, bundled for the bridge.
interface uart_avalon_bridge_if;
  logic [31:0] rx_data;
  logic [1:0]  rx_ctrl;
  logic        rx_done;
  logic [31:0] tx_data;
  logic        tx_flag;
  logic        tx_done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  modport master (
    input  rx_data, rx_ctrl, rx_done, tx_done, avm_readdata, avm_waitrequest,
    output tx_data, tx_flag, avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
  modport slave (
    output rx_data, rx_ctrl, rx_done, tx_done, avm_readdata, avm_waitrequest,
    input  tx_data, tx_flag, avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/uart_avalon_bridge.sv
// uart_avalon_bridge: decodes UART command words into Avalon-MM single-word reads/writes and returns responses over TX.
module uart_avalon_bridge #(
  parameter bit          AUTO_INC       = 1'b1,
  parameter bit          WRITE_ACK      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_WORD       = 32'hDEADBEEF
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  uart_avalon_bridge_if.master        bus,
  output logic                        busy,
  output logic [7:0]                  err_count
);
  typedef enum logic [2:0] {IDLE, BUS_WR, BUS_RD, TX_REQ, TX_WAIT} state_e;
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, tx_data_q, tx_data_d, cnt_q, cnt_d;
  logic        read_q, read_d, write_q, write_d, tx_flag_q, tx_flag_d;
  logic [7:0]  err_q, err_d;
  logic [8:0]  err_sum;
  logic        in_bus, tmo, acc, fin, cmd, overrun, illegal;
  assign in_bus  = state_q == BUS_WR || state_q == BUS_RD;
  assign tmo     = TIMEOUT_CYCLES != 0 && in_bus && bus.avm_waitrequest && cnt_q == 32'(TIMEOUT_CYCLES - 1);
  assign acc     = in_bus && !bus.avm_waitrequest;
  assign fin     = acc || tmo;
  assign cmd     = state_q == IDLE && bus.rx_done;
  assign overrun = state_q != IDLE && bus.rx_done;
  assign illegal = cmd && bus.rx_ctrl == 2'b11;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      tx_flag_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      read_q    <= read_d;
      write_q   <= write_d;
      tx_flag_q <= tx_flag_d;
      err_q     <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = !cmd ? IDLE : bus.rx_ctrl == 2'b01 ? BUS_WR : bus.rx_ctrl == 2'b10 ? BUS_RD : IDLE;
      BUS_WR:  if (fin) state_d = WRITE_ACK ? TX_REQ : IDLE;
      BUS_RD:  if (fin) state_d = TX_REQ;
      TX_REQ:  state_d = TX_WAIT;
      TX_WAIT: if (bus.tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Strobes and tx_flag are pure functions of the next state, so they drop on the accepting edge.
  always_comb begin
    read_d    = state_d == BUS_RD;
    write_d   = state_d == BUS_WR;
    tx_flag_d = state_d == TX_WAIT;
    cnt_d     = in_bus && bus.avm_waitrequest ? cnt_q + 32'd1 : 32'd0;
    addr_d    = cmd && bus.rx_ctrl == 2'b00 ? bus.rx_data : acc && AUTO_INC ? addr_q + 32'd4 : addr_q;
    wdata_d   = cmd && bus.rx_ctrl == 2'b01 ? bus.rx_data : wdata_q;
    tx_data_d = fin && (state_q == BUS_RD || WRITE_ACK) ?
                (tmo ? ERR_WORD : state_q == BUS_RD ? bus.avm_readdata : wdata_q) : tx_data_q;
    err_sum   = {1'b0, err_q} + 9'(tmo) + 9'(overrun) + 9'(illegal);
    err_d     = err_sum[8] ? 8'hFF : err_sum[7:0];
  end
  assign bus.tx_data        = tx_data_q;
  assign bus.tx_flag        = tx_flag_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.avm_byteenable = 4'b1111;
  assign busy               = state_q != IDLE;
  assign err_count          = err_q;
endmodule

// File: tb/tb_uart_avalon_bridge.sv
// tb_uart_avalon_bridge: directed scenario tests for the UART-to-Avalon bridge (AUTO_INC=1, WRITE_ACK=0, TIMEOUT_CYCLES=8).
module tb_uart_avalon_bridge;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       busy;
  logic [7:0] err_count;
  int         passed = 0;
  int         total = 0;
  uart_avalon_bridge_if bif();
  uart_avalon_bridge #(.AUTO_INC(1'b1), .WRITE_ACK(1'b0), .TIMEOUT_CYCLES(8), .ERR_WORD(32'hDEADBEEF)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bif), .busy(busy), .err_count(err_count)
  );
  always #5 CLK = ~CLK;
  task automatic send(input logic [1:0] c, input logic [31:0] d);
    bif.rx_ctrl = c;
    bif.rx_data = d;
    bif.rx_done = 1'b1;
    @(negedge CLK);
    bif.rx_done = 1'b0;
  endtask
  task automatic test_reset;
    #3;
    total++; if (bif.avm_read !== 1'b0) $display("FAIL rst_read got %b exp 0", bif.avm_read); else passed++;
    total++; if (bif.avm_write !== 1'b0) $display("FAIL rst_write got %b exp 0", bif.avm_write); else passed++;
    total++; if (bif.tx_flag !== 1'b0) $display("FAIL rst_tx_flag got %b exp 0", bif.tx_flag); else passed++;
    total++; if (bif.avm_address !== 32'h0) $display("FAIL rst_addr got %h exp 0", bif.avm_address); else passed++;
    total++; if (bif.avm_byteenable !== 4'hF) $display("FAIL rst_be got %h exp f", bif.avm_byteenable); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
    total++; if (err_count !== 8'h0) $display("FAIL rst_err got %h exp 0", err_count); else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask
  task automatic test_write;
    bif.avm_waitrequest = 1'b0;
    send(2'b00, 32'h0000_1000);
    total++; if (bif.avm_address !== 32'h1000) $display("FAIL setaddr got %h exp 1000", bif.avm_address); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL setaddr_busy got %b exp 0", busy); else passed++;
    total++; if (bif.avm_write !== 1'b0) $display("FAIL wr_pre got %b exp 0", bif.avm_write); else passed++;
    send(2'b01, 32'hCAFE_F00D);
    total++; if (bif.avm_write !== 1'b1) $display("FAIL wr_strobe got %b exp 1", bif.avm_write); else passed++;
    total++; if (bif.avm_address !== 32'h1000) $display("FAIL wr_addr got %h exp 1000", bif.avm_address); else passed++;
    total++; if (bif.avm_writedata !== 32'hCAFE_F00D) $display("FAIL wr_data got %h exp cafef00d", bif.avm_writedata); else passed++;
    @(negedge CLK);
    total++; if (bif.avm_write !== 1'b0) $display("FAIL wr_drop got %b exp 0", bif.avm_write); else passed++;
    total++; if (bif.avm_address !== 32'h1004) $display("FAIL wr_inc got %h exp 1004", bif.avm_address); else passed++;
    total++; if (bif.tx_flag !== 1'b0) $display("FAIL wr_noack got %b exp 0", bif.tx_flag); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL wr_busy got %b exp 0", busy); else passed++;
  endtask
  task automatic test_read;
    int n = 0;
    bif.avm_waitrequest = 1'b1;
    bif.avm_readdata = 32'h1234_5678;
    send(2'b10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (bif.avm_read === 1'b1) n++;
      if (i == 3) bif.avm_waitrequest = 1'b0;
      @(negedge CLK);
    end
    total++; if (n !== 4) $display("FAIL rd_hold got %0d exp 4", n); else passed++;
    total++; if (bif.avm_read !== 1'b0) $display("FAIL rd_drop got %b exp 0", bif.avm_read); else passed++;
    total++; if (bif.tx_data !== 32'h1234_5678) $display("FAIL rd_data got %h exp 12345678", bif.tx_data); else passed++;
    total++; if (bif.tx_flag !== 1'b0) $display("FAIL rd_flag_early got %b exp 0", bif.tx_flag); else passed++;
    total++; if (bif.avm_address !== 32'h1008) $display("FAIL rd_inc got %h exp 1008", bif.avm_address); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rd_busy got %b exp 1", busy); else passed++;
    @(negedge CLK);
    total++; if (bif.tx_flag !== 1'b1) $display("FAIL rd_flag_rise got %b exp 1", bif.tx_flag); else passed++;
    @(negedge CLK);
    total++; if (bif.tx_flag !== 1'b1) $display("FAIL rd_flag_hold got %b exp 1", bif.tx_flag); else passed++;
    bif.tx_done = 1'b1;
    @(negedge CLK);
    bif.tx_done = 1'b0;
    total++; if (bif.tx_flag !== 1'b0) $display("FAIL rd_flag_drop got %b exp 0", bif.tx_flag); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rd_idle got %b exp 0", busy); else passed++;
  endtask
  task automatic test_timeout;
    int n = 0;
    bif.avm_waitrequest = 1'b1;
    send(2'b10, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (bif.avm_read === 1'b1) n++;
      @(negedge CLK);
    end
    total++; if (n !== 8) $display("FAIL to_hold got %0d exp 8", n); else passed++;
    total++; if (bif.tx_data !== 32'hDEADBEEF) $display("FAIL to_word got %h exp deadbeef", bif.tx_data); else passed++;
    total++; if (err_count !== 8'd1) $display("FAIL to_err got %0d exp 1", err_count); else passed++;
    total++; if (bif.avm_address !== 32'h1008) $display("FAIL to_addr got %h exp 1008", bif.avm_address); else passed++;
    total++; if (bif.tx_flag !== 1'b1) $display("FAIL to_flag got %b exp 1", bif.tx_flag); else passed++;
    bif.avm_waitrequest = 1'b0;
    bif.tx_done = 1'b1;
    @(negedge CLK);
    bif.tx_done = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL to_idle got %b exp 0", busy); else passed++;
  endtask
  task automatic test_wrap;
    send(2'b00, 32'hFFFF_FFFC);
    send(2'b01, 32'h0000_00A1);
    total++; if (bif.avm_address !== 32'hFFFF_FFFC) $display("FAIL wrap_a1 got %h exp fffffffc", bif.avm_address); else passed++;
    @(negedge CLK);
    total++; if (bif.avm_address !== 32'h0) $display("FAIL wrap_inc got %h exp 0", bif.avm_address); else passed++;
    send(2'b01, 32'h0000_00B2);
    total++; if (bif.avm_write !== 1'b1) $display("FAIL wrap_w2 got %b exp 1", bif.avm_write); else passed++;
    total++; if (bif.avm_address !== 32'h0) $display("FAIL wrap_a2 got %h exp 0", bif.avm_address); else passed++;
    total++; if (bif.avm_writedata !== 32'hB2) $display("FAIL wrap_d2 got %h exp b2", bif.avm_writedata); else passed++;
    @(negedge CLK);
    total++; if (bif.avm_address !== 32'h4) $display("FAIL wrap_next got %h exp 4", bif.avm_address); else passed++;
  endtask
  task automatic test_overrun;
    bif.avm_readdata = 32'h55AA_55AA;
    send(2'b10, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    send(2'b01, 32'h0000_0077);
    total++; if (err_count !== 8'd2) $display("FAIL ovr_err got %0d exp 2", err_count); else passed++;
    total++; if (bif.avm_write !== 1'b0) $display("FAIL ovr_nowrite got %b exp 0", bif.avm_write); else passed++;
    total++; if (bif.tx_data !== 32'h55AA_55AA) $display("FAIL ovr_txdata got %h exp 55aa55aa", bif.tx_data); else passed++;
    total++; if (bif.tx_flag !== 1'b1) $display("FAIL ovr_flag got %b exp 1", bif.tx_flag); else passed++;
    bif.tx_done = 1'b1;
    @(negedge CLK);
    bif.tx_done = 1'b0;
    total++; if (busy !== 1'b0 || bif.avm_write !== 1'b0) $display("FAIL ovr_idle got busy=%b wr=%b exp 0 0", busy, bif.avm_write); else passed++;
    send(2'b11, 32'h0);
    total++; if (err_count !== 8'd3) $display("FAIL ill_err got %0d exp 3", err_count); else passed++;
    total++; if ({busy, bif.avm_read, bif.avm_write} !== 3'b000) $display("FAIL ill_nobus got %b exp 000", {busy, bif.avm_read, bif.avm_write}); else passed++;
    total++; if (bif.avm_address !== 32'h8) $display("FAIL ill_addr got %h exp 8", bif.avm_address); else passed++;
  endtask
  task automatic test_coincide;
    bif.avm_waitrequest = 1'b1;
    send(2'b10, 32'h0);
    for (int i = 0; i < 7; i++) @(negedge CLK);
    send(2'b01, 32'h0000_0099);
    total++; if (err_count !== 8'd5) $display("FAIL both_err got %0d exp 5", err_count); else passed++;
    total++; if (bif.avm_read !== 1'b0 || bif.avm_write !== 1'b0) $display("FAIL both_strobe got rd=%b wr=%b exp 0 0", bif.avm_read, bif.avm_write); else passed++;
    total++; if (bif.tx_data !== 32'hDEADBEEF) $display("FAIL both_word got %h exp deadbeef", bif.tx_data); else passed++;
    bif.avm_waitrequest = 1'b0;
    @(negedge CLK);
    bif.tx_done = 1'b1;
    @(negedge CLK);
    bif.tx_done = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL both_idle got %b exp 0", busy); else passed++;
  endtask
  task automatic test_saturate;
    for (int i = 0; i < 249; i++) send(2'b11, 32'h0);
    total++; if (err_count !== 8'hFE) $display("FAIL sat_fe got %h exp fe", err_count); else passed++;
    send(2'b11, 32'h0);
    total++; if (err_count !== 8'hFF) $display("FAIL sat_ff got %h exp ff", err_count); else passed++;
    send(2'b11, 32'h0);
    total++; if (err_count !== 8'hFF) $display("FAIL sat_hold got %h exp ff", err_count); else passed++;
  endtask
  task automatic test_reset_mid;
    bif.avm_waitrequest = 1'b1;
    bif.avm_readdata = 32'h0BAD_F00D;
    send(2'b10, 32'h0);
    total++; if (bif.avm_read !== 1'b1) $display("FAIL mid_read got %b exp 1", bif.avm_read); else passed++;
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    total++; if (bif.avm_read !== 1'b0) $display("FAIL mid_rd got %b exp 0", bif.avm_read); else passed++;
    total++; if (bif.tx_flag !== 1'b0 || busy !== 1'b0) $display("FAIL mid_flag_busy got %b%b exp 00", bif.tx_flag, busy); else passed++;
    total++; if (bif.avm_address !== 32'h0) $display("FAIL mid_addr got %h exp 0", bif.avm_address); else passed++;
    total++; if (err_count !== 8'h0) $display("FAIL mid_err got %h exp 0", err_count); else passed++;
    total++; if (bif.tx_data !== 32'h0) $display("FAIL mid_txdata got %h exp 0", bif.tx_data); else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    bif.avm_waitrequest = 1'b0;
    @(negedge CLK);
    send(2'b10, 32'h0);
    total++; if (bif.avm_read !== 1'b1 || bif.avm_address !== 32'h0) $display("FAIL post_read got rd=%b a=%h exp 1 0", bif.avm_read, bif.avm_address); else passed++;
    @(negedge CLK);
    total++; if (bif.tx_data !== 32'h0BAD_F00D) $display("FAIL post_data got %h exp 0badf00d", bif.tx_data); else passed++;
    total++; if (bif.avm_address !== 32'h4) $display("FAIL post_inc got %h exp 4", bif.avm_address); else passed++;
    @(negedge CLK);
    total++; if (bif.tx_flag !== 1'b1) $display("FAIL post_flag got %b exp 1", bif.tx_flag); else passed++;
    bif.tx_done = 1'b1;
    @(negedge CLK);
    bif.tx_done = 1'b0;
    total++; if (busy !== 1'b0 || bif.tx_flag !== 1'b0) $display("FAIL post_idle got %b%b exp 00", busy, bif.tx_flag); else passed++;
  endtask
  initial begin
    bif.rx_data = '0;
    bif.rx_ctrl = '0;
    bif.rx_done = 1'b0;
    bif.tx_done = 1'b0;
    bif.avm_readdata = '0;
    bif.avm_waitrequest = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_wrap;
    test_overrun;
    test_coincide;
    test_saturate;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
